// File: rtl/reg_serializer.sv
// reg_serializer: valid/ready-loaded parallel-to-serial shifter with sof/eof framing and word count
module reg_serializer #(
  parameter int lsize = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter int GAP = 0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic [lsize-1:0] d_i,
  input  logic ld_i,
  output logic rdy_o,
  output logic sd_o,
  output logic sv_o,
  output logic sof_o,
  output logic eof_o,
  output logic busy_o,
  output logic [15:0] wcnt_o
);
  localparam int BW = $clog2(lsize) + 1;
  localparam logic [BW-1:0] LAST = BW'(lsize - 1);
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;
  state_t state;
  logic [lsize-1:0] sreg;
  logic [BW-1:0] bitcnt, nb;
  logic [3:0] gcnt;
  logic rdy_q, acc;
  assign rdy_o = rdy_q & rst_i;
  assign acc = ld_i & rdy_o;
  assign nb = bitcnt + 1'b1;
  // sreg holds the bits not yet presented, next one always at the head
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state <= S_IDLE;
      sreg <= '0;
      bitcnt <= '0;
      gcnt <= '0;
      wcnt_o <= '0;
      rdy_q <= 1'b1;
      sd_o <= 1'b0;
      sv_o <= 1'b0;
      sof_o <= 1'b0;
      eof_o <= 1'b0;
      busy_o <= 1'b0;
    end else begin
      if (state == S_SHIFT && eof_o) wcnt_o <= wcnt_o + 1'b1;
      if (acc) begin
        state <= S_SHIFT;
        sreg <= MSB_FIRST ? d_i << 1 : d_i >> 1;
        sd_o <= MSB_FIRST ? d_i[lsize-1] : d_i[0];
        bitcnt <= '0;
        sv_o <= 1'b1;
        sof_o <= 1'b1;
        eof_o <= (lsize == 1);
        busy_o <= 1'b1;
        rdy_q <= lsize == 1 && GAP == 0;
      end else if (state == S_SHIFT && !eof_o) begin
        sreg <= MSB_FIRST ? sreg << 1 : sreg >> 1;
        sd_o <= MSB_FIRST ? sreg[lsize-1] : sreg[0];
        bitcnt <= nb;
        sof_o <= 1'b0;
        eof_o <= nb == LAST;
        rdy_q <= nb == LAST && GAP == 0;
      end else if (state == S_SHIFT) begin
        state <= GAP == 0 ? S_IDLE : S_GAP;
        gcnt <= 4'(GAP - 1);
        sd_o <= 1'b0;
        sv_o <= 1'b0;
        sof_o <= 1'b0;
        eof_o <= 1'b0;
        busy_o <= GAP != 0;
        rdy_q <= GAP == 0;
      end else if (state == S_GAP) begin
        gcnt <= gcnt - 1'b1;
        state <= gcnt == 4'd0 ? S_IDLE : S_GAP;
        busy_o <= gcnt != 4'd0;
        rdy_q <= gcnt == 4'd0;
      end
    end
  end
endmodule

// File: tb/tb_reg_serializer.sv
// tb_reg_serializer: two configurations (MSB-first/no gap, LSB-first/gap 2) against a transaction-schedule model
module tb_reg_serializer;
  typedef struct packed {logic rdy, sd, sv, sof, eof, busy;} rec_t;
  logic clk = 1'b0;
  logic rst [2];
  logic ld [2];
  logic [7:0] d [2];
  logic rdy [2], sd [2], sv [2], sof [2], eof [2], busy [2];
  logic [15:0] wcnt [2];
  int checks = 0, errors = 0;
  rec_t cur [2];
  logic act [2], armed [2];
  logic [7:0] wd [2], sh [2], lastw [2];
  logic [15:0] mw [2];
  int pos [2], run [2], maxrun [2];

  always #5 clk = ~clk;

  reg_serializer #(.lsize(8), .MSB_FIRST(1'b1), .GAP(0)) u0 (
    .clk_i(clk), .rst_i(rst[0]), .d_i(d[0]), .ld_i(ld[0]), .rdy_o(rdy[0]), .sd_o(sd[0]),
    .sv_o(sv[0]), .sof_o(sof[0]), .eof_o(eof[0]), .busy_o(busy[0]), .wcnt_o(wcnt[0]));
  reg_serializer #(.lsize(8), .MSB_FIRST(1'b0), .GAP(2)) u1 (
    .clk_i(clk), .rst_i(rst[1]), .d_i(d[1]), .ld_i(ld[1]), .rdy_o(rdy[1]), .sd_o(sd[1]),
    .sv_o(sv[1]), .sof_o(sof[1]), .eof_o(eof[1]), .busy_o(busy[1]), .wcnt_o(wcnt[1]));

  function automatic int gp(int k);
    return k == 0 ? 0 : 2;
  endfunction

  function automatic rec_t idle();
    rec_t r = '0;
    r.rdy = 1'b1;
    return r;
  endfunction

  // cycle p of a transaction: 8 data cycles then the gap cycles
  function automatic rec_t gen(int k, logic [7:0] w, int p);
    rec_t r = '0;
    if (p < 8) begin
      r.sd = w[k == 0 ? 7 - p : p];
      r.sv = 1'b1;
      r.sof = p == 0;
      r.eof = p == 7;
      r.busy = 1'b1;
      r.rdy = p == 7 && gp(k) == 0;
    end else r.busy = 1'b1;
    return r;
  endfunction

  task automatic lit(input string n, input logic [15:0] a, input logic [15:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h want %0h", n, a, e);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    armed = '{1'b0, 1'b0};
    forever begin
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
        if (!rst[k]) begin
          armed[k] = 1'b1;
          act[k] = 1'b0;
          mw[k] = '0;
          cur[k] = idle();
        end else if (armed[k]) begin
          if (cur[k].eof) mw[k]++;
          if (ld[k] && cur[k].rdy) begin
            act[k] = 1'b1;
            wd[k] = d[k];
            pos[k] = 0;
          end else if (act[k]) begin
            pos[k]++;
            if (pos[k] >= 8 + gp(k)) act[k] = 1'b0;
          end
          cur[k] = act[k] ? gen(k, wd[k], pos[k]) : idle();
        end
      end
    end
  end

  initial begin
    logic [21:0] e, a;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (armed[k]) begin
          e = {cur[k].rdy & rst[k], cur[k].sd, cur[k].sv, cur[k].sof, cur[k].eof, cur[k].busy, mw[k]};
          a = {rdy[k], sd[k], sv[k], sof[k], eof[k], busy[k], wcnt[k]};
          checks++;
          if (a !== e) begin
            errors++;
            $display("FAIL cycle inst%0d {rdy,sd,sv,sof,eof,busy,wcnt} got %h want %h at %0t", k, a, e, $time);
          end
        end
      end
    end
  end

  initial begin
    sh = '{8'h0, 8'h0};
    lastw = '{8'h0, 8'h0};
    run = '{0, 0};
    maxrun = '{0, 0};
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (sv[k] === 1'b1) begin
          if (sof[k]) sh[k] = 8'h0;
          sh[k] = k == 0 ? {sh[k][6:0], sd[k]} : {sd[k], sh[k][7:1]};
          if (eof[k]) lastw[k] = sh[k];
          run[k]++;
          if (run[k] > maxrun[k]) maxrun[k] = run[k];
        end else run[k] = 0;
      end
    end
  end

  initial begin
    rst = '{1'b0, 1'b0};
    ld = '{1'b1, 1'b0};
    d = '{8'h5A, 8'h00};
    repeat (2) cyc();
    @(negedge clk);
    lit("rst_sv", 16'(sv[0]), 16'h0);
    lit("rst_rdy", 16'(rdy[0]), 16'h0);
    lit("rst_busy", 16'(busy[0]), 16'h0);
    lit("rst_wcnt", wcnt[0], 16'h0);
    cyc();
    rst = '{1'b1, 1'b1};
    @(negedge clk);
    lit("rel_rdy", 16'(rdy[0]), 16'h1);
    cyc();
    @(negedge clk);
    lit("first_sv", 16'(sv[0]), 16'h1);
    lit("first_sof", 16'(sof[0]), 16'h1);
    lit("first_sd", 16'(sd[0]), 16'h0);
    ld[0] = 1'b0;
    repeat (10) cyc();
    lit("w5a_word", 16'(lastw[0]), 16'h5A);
    lit("w5a_wcnt", wcnt[0], 16'h1);
    ld[0] = 1'b1;
    d[0] = 8'hA5;
    cyc();
    ld[0] = 1'b0;
    d[0] = 8'h00;
    repeat (10) cyc();
    lit("wa5_word", 16'(lastw[0]), 16'hA5);
    lit("wa5_wcnt", wcnt[0], 16'h2);
    maxrun[0] = 0;
    ld[0] = 1'b1;
    d[0] = 8'h01;
    cyc();
    d[0] = 8'h80;
    repeat (8) cyc();
    ld[0] = 1'b0;
    repeat (10) cyc();
    lit("b2b_word", 16'(lastw[0]), 16'h80);
    lit("b2b_wcnt", wcnt[0], 16'h4);
    lit("b2b_run", 16'(maxrun[0]), 16'd16);
    ld[0] = 1'b1;
    d[0] = 8'h3C;
    cyc();
    d[0] = 8'hFF;
    repeat (6) cyc();
    ld[0] = 1'b0;
    repeat (10) cyc();
    lit("ign_word", 16'(lastw[0]), 16'h3C);
    lit("ign_wcnt", wcnt[0], 16'h5);
    ld[0] = 1'b1;
    d[0] = 8'hC3;
    cyc();
    ld[0] = 1'b0;
    repeat (3) cyc();
    rst[0] = 1'b0;
    cyc();
    @(negedge clk);
    lit("mid_rst_sv", 16'(sv[0]), 16'h0);
    lit("mid_rst_wcnt", wcnt[0], 16'h0);
    lit("mid_rst_rdy", 16'(rdy[0]), 16'h0);
    cyc();
    rst[0] = 1'b1;
    ld[0] = 1'b1;
    d[0] = 8'h0F;
    cyc();
    ld[0] = 1'b0;
    repeat (10) cyc();
    lit("post_rst_word", 16'(lastw[0]), 16'h0F);
    lit("post_rst_wcnt", wcnt[0], 16'h1);
    ld[1] = 1'b1;
    d[1] = 8'h03;
    cyc();
    repeat (8) cyc();
    @(negedge clk);
    lit("gap1_sv", 16'(sv[1]), 16'h0);
    lit("gap1_rdy", 16'(rdy[1]), 16'h0);
    lit("gap1_busy", 16'(busy[1]), 16'h1);
    cyc();
    @(negedge clk);
    lit("gap2_busy", 16'(busy[1]), 16'h1);
    lit("gap2_rdy", 16'(rdy[1]), 16'h0);
    cyc();
    @(negedge clk);
    lit("gap_idle_rdy", 16'(rdy[1]), 16'h1);
    lit("gap_idle_busy", 16'(busy[1]), 16'h0);
    lit("gap_idle_sv", 16'(sv[1]), 16'h0);
    cyc();
    @(negedge clk);
    lit("gap_next_sof", 16'(sof[1]), 16'h1);
    lit("gap_next_sd", 16'(sd[1]), 16'h1);
    ld[1] = 1'b0;
    repeat (12) cyc();
    lit("lsb_word", 16'(lastw[1]), 16'h03);
    lit("lsb_wcnt", wcnt[1], 16'h2);
    repeat (3000) begin
      for (int k = 0; k < 2; k++) begin
        rst[k] = $urandom_range(0, 199) != 0;
        ld[k] = $urandom_range(0, 3) != 0;
        d[k] = 8'($urandom);
      end
      cyc();
    end
    rst = '{1'b1, 1'b1};
    ld = '{1'b0, 1'b0};
    repeat (20) cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
